// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot control bit positions, MIPS opcode/funct
// codes and the issued-entry record used by the decode/issue stage.
package alu_pkg;

  localparam int ALU_CTRL_W = 12;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_SLT  = 4'd2;
  localparam logic [3:0] ALU_OP_SLTU = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [3:0] ALU_OP_NOR  = 4'd5;
  localparam logic [3:0] ALU_OP_OR   = 4'd6;
  localparam logic [3:0] ALU_OP_XOR  = 4'd7;
  localparam logic [3:0] ALU_OP_SLL  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_SRA  = 4'd10;
  localparam logic [3:0] ALU_OP_LUI  = 4'd11;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_SLTIU   = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef logic [ALU_CTRL_W-1:0] aluCtrl_t;

  // Where each ALU operand and the destination index come from
  typedef enum logic [1:0] {SRC1_RS, SRC1_SHAMT, SRC1_ZERO} src1Sel_t;
  typedef enum logic [1:0] {SRC2_RT, SRC2_SEXT, SRC2_ZEXT} src2Sel_t;
  typedef enum logic {DEST_RD, DEST_RT} destSel_t;

  typedef struct packed {
    aluCtrl_t    control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } issueEntry_t;

  function automatic aluCtrl_t aluOneHot(input logic [3:0] idx);
    return aluCtrl_t'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in / ALU-operands-out bundle of the decode-and-issue stage.
// The master side feeds instructions and accepts issued entries; the
// slave side is the stage itself.
interface alu_issue_if;
  import alu_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [31:0]           in_rs_value;
  logic [31:0]           in_rt_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_CTRL_W-1:0] out_alu_control;
  logic [31:0]           out_alu_src1;
  logic [31:0]           out_alu_src2;
  logic [4:0]            out_dest;
  logic                  out_wen;
  logic                  out_illegal;

  modport master (
    output in_valid, in_inst, in_rs_value, in_rt_value, out_ready,
    input  in_ready, out_valid, out_alu_control, out_alu_src1,
           out_alu_src2, out_dest, out_wen, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_rs_value, in_rt_value, out_ready,
    output in_ready, out_valid, out_alu_control, out_alu_src1,
           out_alu_src2, out_dest, out_wen, out_illegal
  );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Purely combinational MIPS32 decoder: instruction plus register values in,
// one-hot ALU control, both operands, destination and write enable out.
// Anything outside the supported set becomes an all-zero illegal bubble.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_rsValue,
  input  logic [31:0] i_rtValue,
  output issueEntry_t o_entry
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic        w_legal;
  logic [3:0]  w_opSel;
  src1Sel_t    w_src1Sel;
  src2Sel_t    w_src2Sel;
  destSel_t    w_destSel;
  logic [4:0]  w_dest;

  assign w_opcode = i_inst[31:26];
  assign w_rt     = i_inst[20:16];
  assign w_rd     = i_inst[15:11];
  assign w_shamt  = i_inst[10:6];
  assign w_funct  = i_inst[5:0];
  assign w_imm    = i_inst[15:0];

  // Classify the instruction: which ALU op and where operands come from
  always_comb begin
    w_legal   = 1'b1;
    w_opSel   = ALU_OP_ADD;
    w_src1Sel = SRC1_RS;
    w_src2Sel = SRC2_RT;
    w_destSel = DEST_RD;
    if (w_opcode == OPC_SPECIAL) begin
      case (w_funct)
        FN_ADD, FN_ADDU: w_opSel = ALU_OP_ADD;
        FN_SUB, FN_SUBU: w_opSel = ALU_OP_SUB;
        FN_SLT:          w_opSel = ALU_OP_SLT;
        FN_SLTU:         w_opSel = ALU_OP_SLTU;
        FN_AND:          w_opSel = ALU_OP_AND;
        FN_NOR:          w_opSel = ALU_OP_NOR;
        FN_OR:           w_opSel = ALU_OP_OR;
        FN_XOR:          w_opSel = ALU_OP_XOR;
        FN_SLLV:         w_opSel = ALU_OP_SLL;
        FN_SRLV:         w_opSel = ALU_OP_SRL;
        FN_SRAV:         w_opSel = ALU_OP_SRA;
        FN_SLL: begin w_opSel = ALU_OP_SLL; w_src1Sel = SRC1_SHAMT; end
        FN_SRL: begin w_opSel = ALU_OP_SRL; w_src1Sel = SRC1_SHAMT; end
        FN_SRA: begin w_opSel = ALU_OP_SRA; w_src1Sel = SRC1_SHAMT; end
        default:         w_legal = 1'b0;
      endcase
    end else begin
      w_destSel = DEST_RT;
      case (w_opcode)
        OPC_ADDI, OPC_ADDIU: begin w_opSel = ALU_OP_ADD;  w_src2Sel = SRC2_SEXT; end
        OPC_SLTI:            begin w_opSel = ALU_OP_SLT;  w_src2Sel = SRC2_SEXT; end
        OPC_SLTIU:           begin w_opSel = ALU_OP_SLTU; w_src2Sel = SRC2_SEXT; end
        OPC_ANDI:            begin w_opSel = ALU_OP_AND;  w_src2Sel = SRC2_ZEXT; end
        OPC_ORI:             begin w_opSel = ALU_OP_OR;   w_src2Sel = SRC2_ZEXT; end
        OPC_XORI:            begin w_opSel = ALU_OP_XOR;  w_src2Sel = SRC2_ZEXT; end
        OPC_LUI: begin
          w_opSel   = ALU_OP_LUI;
          w_src1Sel = SRC1_ZERO;
          w_src2Sel = SRC2_ZEXT;
        end
        default:             w_legal = 1'b0;
      endcase
    end
  end

  assign w_dest = (w_destSel == DEST_RD) ? w_rd : w_rt;

  // Build the issued entry; illegal instructions collapse to all-zero data
  always_comb begin
    o_entry = '0;
    o_entry.illegal = !w_legal;
    if (w_legal) begin
      o_entry.control = aluOneHot(w_opSel);
      case (w_src1Sel)
        SRC1_SHAMT: o_entry.src1 = {27'b0, w_shamt};
        SRC1_ZERO:  o_entry.src1 = 32'b0;
        default:    o_entry.src1 = i_rsValue;
      endcase
      case (w_src2Sel)
        SRC2_SEXT: o_entry.src2 = {{16{w_imm[15]}}, w_imm};
        SRC2_ZEXT: o_entry.src2 = {16'b0, w_imm};
        default:   o_entry.src2 = i_rtValue;
      endcase
      o_entry.dest = w_dest;
      o_entry.wen  = (w_dest != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage: decodes one instruction per cycle and holds the
// result in a single valid/ready pipeline register feeding the ALU.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);

  issueEntry_t w_decoded;
  issueEntry_t r_entry;
  logic        r_valid;
  logic        w_inReady;
  logic        w_inXfer;

  alu_ctrl_decode u_decode (
    .i_inst    (bus.in_inst),
    .i_rsValue (bus.in_rs_value),
    .i_rtValue (bus.in_rt_value),
    .o_entry   (w_decoded)
  );

  assign w_inReady = !r_valid || bus.out_ready;
  assign w_inXfer  = bus.in_valid && w_inReady;

  // Occupancy: fill on accept, empty only when handed over with nothing new
  always_ff @(posedge clk) begin
    if (reset)         r_valid <= 1'b0;
    else if (w_inXfer) r_valid <= 1'b1;
    else if (bus.out_ready) r_valid <= 1'b0;
  end

  // Payload changes only on accept, so it is frozen through stalls
  always_ff @(posedge clk) begin
    if (reset)         r_entry <= '0;
    else if (w_inXfer) r_entry <= w_decoded;
  end

  assign bus.in_ready        = w_inReady;
  assign bus.out_valid       = r_valid;
  assign bus.out_alu_control = r_entry.control;
  assign bus.out_alu_src1    = r_entry.src1;
  assign bus.out_alu_src2    = r_entry.src2;
  assign bus.out_dest        = r_entry.dest;
  assign bus.out_wen         = r_entry.wen;
  assign bus.out_illegal     = r_entry.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver pushes the expected
// entry for every accepted instruction, a monitor pops and compares on
// every handover and checks the entry in flight on every stall cycle.
module tb_alu_issue_stage;

  typedef struct {
    logic [11:0] ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } expEntry_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic monitorOn;
  logic inXferNow;
  int   cycleIdx;
  expEntry_t expQ[$];

  int rFunctOp[64];
  int iOpcOp[64];
  logic [5:0] legalFn[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h27,
                              6'h25, 6'h26, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03};
  logic readyPattern[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference: op number per funct / opcode table, operands chosen by instruction class
  function automatic expEntry_t refModel(input logic [31:0] inst, input logic [31:0] rsv, input logic [31:0] rtv);
    expEntry_t e;
    int opc = int'(inst[31:26]);
    int fn = int'(inst[5:0]);
    int op = -1;
    e.ctrl = 0; e.s1 = 0; e.s2 = 0; e.dest = 0; e.wen = 0; e.illegal = 1;
    if (opc == 0) begin
      op = rFunctOp[fn];
      if (op >= 0) begin
        e.dest = inst[15:11];
        e.s1 = (fn < 4) ? 32'(inst[10:6]) : rsv;
        e.s2 = rtv;
      end
    end else begin
      op = iOpcOp[opc];
      if (op >= 0) begin
        e.dest = inst[20:16];
        if (opc == 'h0F) begin
          e.s1 = 0;
          e.s2 = 32'(inst[15:0]);
        end else begin
          e.s1 = rsv;
          e.s2 = (opc < 'h0C) ? 32'(signed'(inst[15:0])) : 32'(inst[15:0]);
        end
      end
    end
    if (op >= 0) begin
      e.ctrl = 12'(1 << op);
      e.wen = (e.dest != 0);
      e.illegal = 0;
    end
    return e;
  endfunction

  function automatic expEntry_t mk(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d, input logic w, input logic il);
    expEntry_t e;
    e.ctrl = c; e.s1 = a; e.s2 = b; e.dest = d; e.wen = w; e.illegal = il;
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    if (k < 4) begin
      w[31:26] = 6'h00;
      w[5:0] = legalFn[$urandom_range(0, 15)];
    end else if (k < 8) begin
      w[31:26] = 6'(8 + $urandom_range(0, 7));
    end
    return w;
  endfunction

  // One driven cycle; the expected entry is queued only if the stage accepts it
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] rsv,
                               input logic [31:0] rtv, input logic rdy, input expEntry_t e);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_inst = inst;
    bus.in_rs_value = rsv;
    bus.in_rt_value = rtv;
    bus.out_ready = rdy;
    cycleIdx++;
    #1;
    inXferNow = v && bus.in_ready;
    if (inXferNow) expQ.push_back(e);
  endtask

  task automatic drain();
    expEntry_t e = mk(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1, e);
    checkOutput("drain queue empty", 32'(expQ.size()), 0);
  endtask

  // Monitor: compare the entry on the outputs against the queue head each cycle
  always @(negedge clk) begin
    int pending;
    expEntry_t h;
    #2;
    if (monitorOn) begin
      pending = expQ.size() - (inXferNow ? 1 : 0);
      checkOutput("in_ready rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(pending > 0));
      if (bus.out_valid && pending > 0) begin
        h = expQ[0];
        checkOutput("alu_control", 32'(bus.out_alu_control), 32'(h.ctrl));
        checkOutput("alu_src1", bus.out_alu_src1, h.s1);
        checkOutput("alu_src2", bus.out_alu_src2, h.s2);
        checkOutput("dest", 32'(bus.out_dest), 32'(h.dest));
        checkOutput("wen", 32'(bus.out_wen), 32'(h.wen));
        checkOutput("illegal", 32'(bus.out_illegal), 32'(h.illegal));
        if (bus.out_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, " control"}, 32'(bus.out_alu_control), 0);
    checkOutput({tag, " src1"}, bus.out_alu_src1, 0);
    checkOutput({tag, " src2"}, bus.out_alu_src2, 0);
    checkOutput({tag, " dest"}, 32'(bus.out_dest), 0);
    checkOutput({tag, " wen"}, 32'(bus.out_wen), 0);
    checkOutput({tag, " illegal"}, 32'(bus.out_illegal), 0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [31:0] inst;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic accepted;
    compared = 0; mismatched = 0; monitorOn = 0; inXferNow = 0; cycleIdx = 0;
    for (int i = 0; i < 64; i++) begin rFunctOp[i] = -1; iOpcOp[i] = -1; end
    rFunctOp['h20] = 0; rFunctOp['h21] = 0; rFunctOp['h22] = 1; rFunctOp['h23] = 1;
    rFunctOp['h2A] = 2; rFunctOp['h2B] = 3; rFunctOp['h24] = 4; rFunctOp['h27] = 5;
    rFunctOp['h25] = 6; rFunctOp['h26] = 7; rFunctOp['h00] = 8; rFunctOp['h04] = 8;
    rFunctOp['h02] = 9; rFunctOp['h06] = 9; rFunctOp['h03] = 10; rFunctOp['h07] = 10;
    iOpcOp['h08] = 0; iOpcOp['h09] = 0; iOpcOp['h0A] = 2; iOpcOp['h0B] = 3;
    iOpcOp['h0C] = 4; iOpcOp['h0D] = 6; iOpcOp['h0E] = 7; iOpcOp['h0F] = 11;

    reset = 1'b1;
    bus.in_valid = 0; bus.in_inst = 0; bus.in_rs_value = 0; bus.in_rt_value = 0; bus.out_ready = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkAllZero("reset state");
    monitorOn = 1;

    // Hand-derived entries, back to back with the execute stage always ready
    applyStimulus(1, 32'h2528FFFF, 32'h5, 32'h77, 1, mk(12'h001, 32'h5, 32'hFFFFFFFF, 8, 1, 0));
    applyStimulus(1, 32'h00031100, 32'h9, 32'hF, 1, mk(12'h100, 32'h4, 32'hF, 2, 1, 0));
    applyStimulus(1, 32'h00621007, 32'h24, 32'h80000000, 1, mk(12'h400, 32'h24, 32'h80000000, 2, 1, 0));
    applyStimulus(1, 32'h3C051234, 32'hAA, 32'hBB, 1, mk(12'h800, 32'h0, 32'h1234, 5, 1, 0));
    applyStimulus(1, 32'h34058000, 32'h11, 32'h22, 1, mk(12'h040, 32'h11, 32'h8000, 5, 1, 0));
    applyStimulus(1, 32'hFC000000, 32'h33, 32'h44, 1, mk(12'h000, 32'h0, 32'h0, 0, 0, 1));
    applyStimulus(1, 32'h00000000, 32'h55, 32'h0, 1, mk(12'h100, 32'h0, 32'h0, 0, 0, 0));
    drain();

    // Stream of 8 with out_ready cycling 1,0,0,1; each instruction retried until taken
    for (int n = 0; n < 8; n++) begin
      inst = randInst(); rsv = $urandom; rtv = $urandom;
      accepted = 0;
      for (int t = 0; t < 10 && !accepted; t++) begin
        applyStimulus(1, inst, rsv, rtv, readyPattern[cycleIdx % 4], refModel(inst, rsv, rtv));
        accepted = inXferNow;
      end
      if (!accepted) begin
        mismatched++;
        $display("[TB] FAIL stream accept: got no accept, expected accept within 10 cycles");
      end
    end
    drain();

    // Random traffic on both sides
    for (int n = 0; n < 400; n++) begin
      inst = randInst(); rsv = $urandom; rtv = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, inst, rsv, rtv, $urandom_range(0, 2) != 0,
                    refModel(inst, rsv, rtv));
    end
    drain();

    // Reset while an entry is stalled on the output
    applyStimulus(1, 32'h3C051234, 0, 0, 0, refModel(32'h3C051234, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    monitorOn = 0;
    inXferNow = 0;
    reset = 1'b1;
    bus.in_valid = 1; bus.in_inst = 32'h2528FFFF; bus.in_rs_value = 5; bus.out_ready = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 0;
    #1;
    checkAllZero("mid-stall reset");
    expQ.delete();
    monitorOn = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
